// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch PC, in-order word reads and a prefetch FIFO feeding decode.
// Defining IFU_PERF_CNT_EN adds the fetchCnt/flushCnt event counters.
module instr_fetch_unit #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rstN,
   input  logic        redirectValid,
   input  logic [31:0] redirectPc,
   output logic [31:0] pcPlus4,
   output logic        memReqValid,
   input  logic        memReqReady,
   output logic [31:0] memReqAddr,
   input  logic        memRspValid,
   input  logic [31:0] memRspData,
   output logic        instrValid,
   input  logic        instrReady,
   output logic [31:0] instrData,
`ifdef IFU_PERF_CNT_EN
   output logic [31:0] fetchCnt,
   output logic [31:0] flushCnt,
`endif
   output logic [31:0] instrPc
);
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [PW-1:0] wr_q, wr_d, rd_q, rd_d, tw_q, tw_d, tr_q, tr_d;
   logic [CW-1:0] count_q, count_d, inflight_q, inflight_d, drop_q, drop_d;
   logic [31:0] fpc_q [FIFO_DEPTH];
   logic [31:0] fpc_d [FIFO_DEPTH];
   logic [31:0] fdat_q [FIFO_DEPTH];
   logic [31:0] fdat_d [FIFO_DEPTH];
   logic [31:0] tag_q [FIFO_DEPTH];
   logic [31:0] tag_d [FIFO_DEPTH];
   logic acc, rsp_run, push, pop;
   assign memReqValid = (state_q == RUN) && ((count_q + inflight_q) < CW'(FIFO_DEPTH));
   assign memReqAddr  = fetch_pc_q;
   assign pcPlus4     = fetch_pc_q + 32'd4;
   assign instrValid  = count_q != '0;
   assign instrData   = instrValid ? fdat_q[rd_q] : 32'd0;
   assign instrPc     = instrValid ? fpc_q[rd_q] : 32'd0;
   assign acc         = memReqValid && memReqReady;
   assign rsp_run     = memRspValid && (state_q == RUN);
   assign push        = rsp_run && !redirectValid;
   assign pop         = instrValid && instrReady && !redirectValid;
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      wr_d       = wr_q;
      rd_d       = rd_q;
      tw_d       = tw_q;
      tr_d       = tr_q;
      drop_d     = drop_q;
      fpc_d      = fpc_q;
      fdat_d     = fdat_q;
      tag_d      = tag_q;
      count_d    = count_q + CW'(push) - CW'(pop);
      inflight_d = inflight_q + CW'(acc) - CW'(rsp_run);
      if (acc) begin
         tag_d[tw_q] = fetch_pc_q;
         tw_d        = tw_q + PW'(1);
         fetch_pc_d  = fetch_pc_q + 32'd4;
      end
      if (rsp_run) tr_d = tr_q + PW'(1);
      if (push) begin
         fpc_d[wr_q]  = tag_q[tr_q];
         fdat_d[wr_q] = memRspData;
         wr_d         = wr_q + PW'(1);
      end
      if (pop) rd_d = rd_q + PW'(1);
      if (state_q == IDLE) state_d = RUN;
      if (state_q == DRAIN) drop_d = drop_q - CW'(memRspValid);
      // Everything still owed by memory at a redirect becomes a response to discard
      if (redirectValid) begin
         fetch_pc_d = redirectPc & ~32'd3;
         {wr_d, rd_d, tw_d, tr_d} = '0;
         count_d    = '0;
         inflight_d = '0;
         drop_d     = ((state_q == DRAIN) ? drop_q : inflight_q) + CW'(acc) - CW'(memRspValid);
      end
      if (redirectValid || state_q == DRAIN) state_d = (drop_d != '0) ? DRAIN : RUN;
   end
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         wr_q       <= '0;
         rd_q       <= '0;
         tw_q       <= '0;
         tr_q       <= '0;
         count_q    <= '0;
         inflight_q <= '0;
         drop_q     <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         tw_q       <= tw_d;
         tr_q       <= tr_d;
         count_q    <= count_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
      end
   end
   always_ff @(posedge clk) begin
      fpc_q  <= fpc_d;
      fdat_q <= fdat_d;
      tag_q  <= tag_d;
   end
`ifdef IFU_PERF_CNT_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d, flush_cnt_q, flush_cnt_d;
   always_comb begin
      fetch_cnt_d = fetch_cnt_q + 32'(acc);
      flush_cnt_d = flush_cnt_q + 32'(redirectValid);
   end
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         fetch_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end
   assign fetchCnt = fetch_cnt_q;
   assign flushCnt = flush_cnt_q;
`endif
endmodule
